// File: rtl/cpu_pkg.sv
// Shared definitions for the WISC CPU front end: widths, fetch FSM encoding,
// HLT opcode and the IF/ID record layout.
package cpu_pkg;

  localparam int unsigned PC_WIDTH    = 16;
  localparam int unsigned INSTR_WIDTH = 16;
  localparam int unsigned OPC_WIDTH   = 4;

  localparam logic [PC_WIDTH-1:0]  PC_STEP     = PC_WIDTH'(2);
  localparam logic [OPC_WIDTH-1:0] HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetchState_e;

  typedef struct packed {
    logic                   valid;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pcPlus2;
  } ifid_t;

  function automatic logic isHalt(input logic [INSTR_WIDTH-1:0] instr);
    return instr[INSTR_WIDTH-1 -: OPC_WIDTH] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Flush only drops valid; load captures a full record.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem handshake, stall/redirect/HLT handling.
// Optional counters perf_fetched/perf_wait enabled by `define FETCH_PERF_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] PC_RESET = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rdy,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   ifid_valid,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc_plus2,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   fetch_halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]            perf_fetched,
  output logic [15:0]            perf_wait
`endif
);

  fetchState_e         state, stateNext;
  logic [PC_WIDTH-1:0] pc, pcNext, pcPlus;
  logic [PC_WIDTH-1:0] drainAddr, drainAddrNext;
  ifid_t               holdBuf, holdNext;
  ifid_t               fetchRec, ifidD, ifidQ;
  logic                ifidLoad, ifidFlush;
  logic                reqQ, haltedQ;
  logic                unusedBits;

  assign unusedBits = redirect_pc[0];
  assign pcPlus     = pc + PC_STEP;
  assign fetchRec   = '{valid: 1'b1, instr: imem_data, pcPlus2: pcPlus};

  // Next-state, PC and IF/ID control
  always_comb begin
    stateNext     = state;
    pcNext        = pc;
    drainAddrNext = drainAddr;
    holdNext      = holdBuf;
    ifidLoad      = 1'b0;
    ifidFlush     = 1'b0;
    ifidD         = fetchRec;

    if (redirect) begin
      ifidFlush = 1'b1;
      holdNext  = '0;
      pcNext    = {redirect_pc[PC_WIDTH-1:1], 1'b0};
      if (!imem_rdy && (state == RUN || state == DRAIN)) begin
        stateNext = DRAIN;
      end else begin
        stateNext = RUN;
      end
      if (state == RUN && !imem_rdy) begin
        drainAddrNext = pc;
      end
    end else begin
      case (state)
        RUN: begin
          if (imem_rdy) begin
            if (!isHalt(imem_data)) begin
              pcNext = pcPlus;
            end
            if (stall) begin
              holdNext  = fetchRec;
              stateNext = HOLD;
            end else begin
              ifidLoad  = 1'b1;
              stateNext = isHalt(imem_data) ? HALTED : RUN;
            end
          end else if (!stall) begin
            ifidFlush = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifidLoad  = 1'b1;
            ifidD     = holdBuf;
            holdNext  = '0;
            stateNext = isHalt(holdBuf.instr) ? HALTED : RUN;
          end
        end
        HALTED: begin
          if (!stall) begin
            ifidFlush = 1'b1;
          end
        end
        DRAIN: begin
          if (imem_rdy) begin
            stateNext = RUN;
          end
        end
        default: stateNext = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= PC_RESET;
      drainAddr <= '0;
      holdBuf   <= '0;
      reqQ      <= 1'b1;
      haltedQ   <= 1'b0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      drainAddr <= drainAddrNext;
      holdBuf   <= holdNext;
      reqQ      <= (stateNext == RUN) || (stateNext == DRAIN);
      haltedQ   <= (stateNext == HALTED);
    end
  end

  ifid_reg u_ifid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ifidLoad),
    .flush (ifidFlush),
    .d     (ifidD),
    .q     (ifidQ)
  );

  assign imem_req      = reqQ;
  assign imem_addr     = (state == DRAIN) ? drainAddr : pc;
  assign ifid_valid    = ifidQ.valid;
  assign ifid_instr    = ifidQ.instr;
  assign ifid_pc_plus2 = ifidQ.pcPlus2;
  assign pc_out        = pc;
  assign fetch_halted  = haltedQ;

`ifdef FETCH_PERF_EN
  logic [15:0] fetchedCnt, waitCnt;

  // Saturating counters; a flushed load never reaches IF/ID so it is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchedCnt <= '0;
      waitCnt    <= '0;
    end else begin
      if (ifidLoad && !ifidFlush && fetchedCnt != 16'hFFFF) begin
        fetchedCnt <= fetchedCnt + 16'd1;
      end
      if (reqQ && !imem_rdy && waitCnt != 16'hFFFF) begin
        waitCnt <= waitCnt + 16'd1;
      end
    end
  end

  assign perf_fetched = fetchedCnt;
  assign perf_wait    = waitCnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset-in-DRAIN sequence,
// then random traffic against a rule-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect, imem_rdy;
  logic [15:0] redirect_pc, imem_data;
  logic        imem_req, ifid_valid, fetch_halted;
  logic [15:0] imem_addr, ifid_instr, ifid_pc_plus2, pc_out;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_wait;
`endif

  logic [15:0] mem [0:255];
  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[8:1]];

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdy      (imem_rdy),
    .imem_data     (imem_data),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .pc_out        (pc_out),
    .fetch_halted  (fetch_halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_wait     (perf_wait)
`endif
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        s, r;
    logic [15:0] rpc;
    logic        rdy;
    logic        v;
    logic [15:0] instr, pc2, pc;
    logic        req;
    logic [15:0] addr;
    logic        h;
  } vec_t;

  function automatic vec_t mk(input logic s, r, input logic [15:0] rpc, input logic rdy,
                              input logic v, input logic [15:0] instr, pc2, pc,
                              input logic req, input logic [15:0] addr, input logic h);
    vec_t x;
    x.s = s; x.r = r; x.rpc = rpc; x.rdy = rdy; x.v = v; x.instr = instr;
    x.pc2 = pc2; x.pc = pc; x.req = req; x.addr = addr; x.h = h;
    return x;
  endfunction

  // Reference model: architectural view of the fetch stage
  logic [15:0] mPc, mIfInstr, mIfPc2, mHeldInstr, mHeldPc2, mDrainAddr, mFetched, mWait;
  logic        mIfValid, mHeld, mHalted, mDraining;

  function automatic logic isHlt(input logic [15:0] w);
    return w[15:12] == 4'hF;
  endfunction

  task automatic modelReset();
    mPc = 16'h0000; mIfValid = 1'b0; mIfInstr = 16'h0000; mIfPc2 = 16'h0000;
    mHeld = 1'b0; mHalted = 1'b0; mDraining = 1'b0; mDrainAddr = 16'h0000;
    mHeldInstr = 16'h0000; mHeldPc2 = 16'h0000; mFetched = 16'h0000; mWait = 16'h0000;
  endtask

  task automatic modelLoad(input logic [15:0] w, input logic [15:0] p2);
    mIfValid = 1'b1; mIfInstr = w; mIfPc2 = p2;
    if (mFetched != 16'hFFFF) mFetched = mFetched + 16'd1;
  endtask

  task automatic modelStep(input logic s, input logic r, input logic [15:0] rpc, input logic rdy);
    logic [15:0] addr, d;
    logic        req;
    addr = mDraining ? mDrainAddr : mPc;
    d    = mem[addr[8:1]];
    req  = !mHeld && !mHalted;
    if (req && !rdy && mWait != 16'hFFFF) mWait = mWait + 16'd1;
    if (r) begin
      mIfValid = 1'b0;
      if (req && !rdy) begin
        if (!mDraining) mDrainAddr = mPc;
        mDraining = 1'b1;
      end else begin
        mDraining = 1'b0;
      end
      mHeld = 1'b0; mHalted = 1'b0;
      mPc = {rpc[15:1], 1'b0};
    end else if (mDraining) begin
      if (rdy) mDraining = 1'b0;
    end else if (mHeld) begin
      if (!s) begin
        modelLoad(mHeldInstr, mHeldPc2);
        mHeld = 1'b0;
        mHalted = isHlt(mHeldInstr);
      end
    end else if (mHalted) begin
      if (!s) mIfValid = 1'b0;
    end else if (rdy) begin
      if (s) begin
        mHeld = 1'b1; mHeldInstr = d; mHeldPc2 = mPc + 16'd2;
      end else begin
        modelLoad(d, mPc + 16'd2);
        mHalted = isHlt(d);
      end
      if (!isHlt(d)) mPc = mPc + 16'd2;
    end else if (!s) begin
      mIfValid = 1'b0;
    end
  endtask

  vec_t tbl [18];

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; imem_rdy = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'hF000;
    mem[8] = 16'h5A5A; mem[8'h20] = 16'h7777; mem[255] = 16'h1111;

    //            s  r  rpc       rdy v  instr     pc2       pc        req addr      h
    tbl[0]  = mk(0, 0, 16'h0000, 1,  1, 16'h1234, 16'h0002, 16'h0002, 1, 16'h0002, 0);
    tbl[1]  = mk(0, 0, 16'h0000, 1,  1, 16'h2345, 16'h0004, 16'h0004, 1, 16'h0004, 0);
    tbl[2]  = mk(0, 0, 16'h0000, 1,  1, 16'hF000, 16'h0006, 16'h0004, 0, 16'h0000, 1);
    tbl[3]  = mk(0, 0, 16'h0000, 0,  0, 16'hF000, 16'h0006, 16'h0004, 0, 16'h0000, 1);
    tbl[4]  = mk(1, 0, 16'h0000, 0,  0, 16'hF000, 16'h0006, 16'h0004, 0, 16'h0000, 1);
    tbl[5]  = mk(1, 1, 16'h0011, 0,  0, 16'hF000, 16'h0006, 16'h0010, 1, 16'h0010, 0);
    tbl[6]  = mk(1, 0, 16'h0000, 1,  0, 16'hF000, 16'h0006, 16'h0012, 0, 16'h0000, 0);
    tbl[7]  = mk(1, 0, 16'h0000, 0,  0, 16'hF000, 16'h0006, 16'h0012, 0, 16'h0000, 0);
    tbl[8]  = mk(0, 0, 16'h0000, 0,  1, 16'h5A5A, 16'h0012, 16'h0012, 1, 16'h0012, 0);
    tbl[9]  = mk(0, 1, 16'h0008, 1,  0, 16'h5A5A, 16'h0012, 16'h0008, 1, 16'h0008, 0);
    tbl[10] = mk(0, 0, 16'h0000, 0,  0, 16'h5A5A, 16'h0012, 16'h0008, 1, 16'h0008, 0);
    tbl[11] = mk(0, 1, 16'h0041, 0,  0, 16'h5A5A, 16'h0012, 16'h0040, 1, 16'h0008, 0);
    tbl[12] = mk(0, 0, 16'h0000, 0,  0, 16'h5A5A, 16'h0012, 16'h0040, 1, 16'h0008, 0);
    tbl[13] = mk(0, 0, 16'h0000, 1,  0, 16'h5A5A, 16'h0012, 16'h0040, 1, 16'h0040, 0);
    tbl[14] = mk(0, 0, 16'h0000, 1,  1, 16'h7777, 16'h0042, 16'h0042, 1, 16'h0042, 0);
    tbl[15] = mk(1, 1, 16'h0100, 1,  0, 16'h7777, 16'h0042, 16'h0100, 1, 16'h0100, 0);
    tbl[16] = mk(0, 1, 16'hFFFE, 1,  0, 16'h7777, 16'h0042, 16'hFFFE, 1, 16'hFFFE, 0);
    tbl[17] = mk(0, 0, 16'h0000, 1,  1, 16'h1111, 16'h0000, 16'h0000, 1, 16'h0000, 0);

    repeat (2) @(negedge clk);
    check("rst_valid", 16'(ifid_valid), 16'h0);
    check("rst_instr", ifid_instr, 16'h0);
    check("rst_pc2", ifid_pc_plus2, 16'h0);
    check("rst_pc", pc_out, 16'h0);
    check("rst_halted", 16'(fetch_halted), 16'h0);
    check("rst_req", 16'(imem_req), 16'h1);
    check("rst_addr", imem_addr, 16'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      stall = tbl[i].s; redirect = tbl[i].r; redirect_pc = tbl[i].rpc; imem_rdy = tbl[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), 16'(ifid_valid), 16'(tbl[i].v));
      check($sformatf("v%0d_instr", i), ifid_instr, tbl[i].instr);
      check($sformatf("v%0d_pc2", i), ifid_pc_plus2, tbl[i].pc2);
      check($sformatf("v%0d_pc", i), pc_out, tbl[i].pc);
      check($sformatf("v%0d_req", i), 16'(imem_req), 16'(tbl[i].req));
      if (tbl[i].req) check($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      check($sformatf("v%0d_halted", i), 16'(fetch_halted), 16'(tbl[i].h));
      @(negedge clk);
    end

    // Async reset while draining
    stall = 1'b0; redirect = 1'b0; imem_rdy = 1'b1;
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0200; imem_rdy = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    check("drain_addr", imem_addr, 16'h0002);
    check("drain_pc", pc_out, 16'h0200);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 16'(ifid_valid), 16'h0);
    check("arst_instr", ifid_instr, 16'h0);
    check("arst_pc2", ifid_pc_plus2, 16'h0);
    check("arst_pc", pc_out, 16'h0);
    check("arst_req", 16'(imem_req), 16'h1);
    check("arst_addr", imem_addr, 16'h0);
`ifdef FETCH_PERF_EN
    check("arst_perf_fetched", perf_fetched, 16'h0);
    check("arst_perf_wait", perf_wait, 16'h0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      check("r_valid", 16'(ifid_valid), 16'(mIfValid));
      check("r_instr", ifid_instr, mIfInstr);
      check("r_pc2", ifid_pc_plus2, mIfPc2);
      check("r_pc", pc_out, mPc);
      check("r_halted", 16'(fetch_halted), 16'(mHalted && !mHeld));
      check("r_req", 16'(imem_req), 16'(!mHeld && !mHalted));
      if (!mHeld && !mHalted) check("r_addr", imem_addr, mDraining ? mDrainAddr : mPc);
`ifdef FETCH_PERF_EN
      check("r_perf_fetched", perf_fetched, mFetched);
      check("r_perf_wait", perf_wait, mWait);
`endif
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom);
      imem_rdy    = ($urandom_range(0, 2) != 0);
      modelStep(stall, redirect, redirect_pc, imem_rdy);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 16-bit WISC pipelined CPU. It sits directly upstream of decode.
- Owns the PC register.
- Issues requests to instruction memory over a ready-based handshake, so multi-cycle memory and the later cache are supported.
- Loads the IF/ID pipeline register.
- Honours stall and redirect from the hazard/branch unit.
- Stops fetching once it fetches HLT.

Parameters:
PC_RESET, 16'h0000, PC value after reset
PC_STEP, 2, byte increment per sequential instruction
HALT_OPCODE, 4'hF, instr[15:12] value identifying HLT

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
stall  input  1  IF/ID must hold its contents this cycle
redirect  input  1  branch/jump taken; flush and refetch
redirect_pc  input  16  redirect target; bit 0 forced to 0
imem_req  output  1  fetch request valid
imem_addr  output  16  fetch address; stable while imem_req=1 and imem_rdy=0
imem_rdy  input  1  imem_data valid; request completes this cycle
imem_data  input  16  fetched instruction
ifid_valid  output  1  IF/ID holds a real instruction
ifid_instr  output  16  IF/ID instruction
ifid_pc_plus2  output  16  address of the IF/ID instruction + PC_STEP
pc_out  output  16  current PC register
fetch_halted  output  1  HLT fetched; fetching stopped

Behaviour:
Reset values:
- pc=PC_RESET, state=RUN.
- ifid_valid=0, ifid_instr=16'h0000, ifid_pc_plus2=16'h0000.
- hold buffer empty, fetch_halted=0.

States: RUN, HOLD, DRAIN, HALTED.
- imem_req=1 in RUN and DRAIN, 0 otherwise.
- imem_addr=pc in RUN; in DRAIN it is the registered address of the abandoned request.

RUN:
- imem_rdy=0 and stall=0: ifid_valid<=0 (bubble).
- imem_rdy=0 and stall=1: IF/ID unchanged.
- imem_rdy=1 and stall=0: IF/ID <= {1, imem_data, pc+PC_STEP}.
- imem_rdy=1 and stall=1: imem_data and pc+PC_STEP go to the one-entry hold buffer; state HOLD.
- Any accepted instruction, non-HLT: pc <= pc+PC_STEP.
- Accepted HLT: pc unchanged. Next state is HALTED, or HOLD if stalled (hold buffer marks it as HLT).

HOLD:
- imem_req=0.
- stall=0: IF/ID <= buffer. Next state is HALTED if the buffered instruction is HLT, else RUN.
- stall=1: no change.

HALTED:
- fetch_halted=1, no requests.
- IF/ID follows the stall rule: holds while stall=1, else ifid_valid<=0.
- Exits only on redirect.

Redirect (highest priority, beats stall, any state):
- ifid_valid<=0, hold buffer discarded, fetch_halted<=0, pc <= {redirect_pc[15:1],1'b0}.
- In RUN with imem_rdy=0: next state DRAIN, and the outstanding address is latched.
- Otherwise: next state RUN; same-cycle imem_data is discarded.

DRAIN:
- Keep the request until imem_rdy, discard the data, then go to RUN.
- A further redirect in DRAIN only updates pc.

Arithmetic and latency:
- PC arithmetic is 16-bit unsigned; 16'hFFFE+2 wraps to 16'h0000.
- With zero-wait memory (imem_rdy same cycle) throughput is 1 instruction/cycle.
- IF/ID is updated on the edge ending the rdy cycle.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched[15:0] (instructions loaded into IF/ID, not counting flushed) and perf_wait[15:0] (cycles with imem_req=1 and imem_rdy=0). Both are reset to 0 and saturate at 16'hFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg: fetch state encoding, HALT_OPCODE, PC_STEP, PC_WIDTH/INSTR_WIDTH = 16, and the IF/ID record layout (valid, instr, pc_plus2).
- Sub-module ifid_reg: IF/ID register with load/hold/flush controls, so decode-side verification can probe it directly.
- PC/FSM logic stays in the top.

Test Plan:
1. Zero-wait memory returning 16'h1234, 16'h2345, 16'hF000 from addresses 0, 2, 4 -> IF/ID gets pc_plus2 0x0002, 0x0004, 0x0006 on consecutive cycles; fetch_halted=1; pc_out stays 0x0004; imem_req=0 afterwards.
2. Memory with 3-cycle latency -> imem_addr stable over the wait, ifid_valid=0 bubbles between instructions; with FETCH_PERF_EN, perf_wait increments by 2 per fetch.
3. stall=1 for 2 cycles coincident with imem_rdy at addr 0x0010 -> state HOLD, imem_req=0, IF/ID unchanged; held instr appears the cycle after stall falls, with pc_plus2=0x0012.
4. redirect to 0x0041 while a request to 0x0008 is outstanding -> ifid_valid=0, DRAIN until rdy, data discarded; next request addr 0x0040.
5. redirect=1 and stall=1 in the same cycle, and redirect while HALTED -> flush wins, fetch_halted clears, fetch resumes at the target.
6. PC at 0xFFFE fetching non-HLT; separately, rst_n asserted mid-DRAIN -> pc wraps to 0x0000 with ifid_pc_plus2=0x0000; async reset restores all reset values immediately.
